// File: rtl/filter2d_frame_io.sv
// filter2d_frame_io: frame sequencer around filter2d sharing one single-port SRAM.
// Loads a WIDTH x WIDTH pixel frame into words 0..NPIX-1, kicks the filter,
// waits for its finish, then streams words NPIX..2*NPIX-1 out through a
// 2-entry skid FIFO that absorbs the one-cycle SRAM read latency.
module filter2d_frame_io #(
   parameter int WIDTH = 256,
   parameter int AW    = 17
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          frame_go,
   output logic          busy,
   output logic          frame_done,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [7:0]    s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [7:0]    m_data,
   output logic          m_last,
   output logic          sram_cs,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [7:0]    sram_din,
   input  logic [7:0]    sram_dout,
   output logic          flt_start,
   input  logic          flt_finish,
   output logic          flt_owns_sram
);

   localparam int NPIX = WIDTH * WIDTH;
   localparam int CW   = AW - 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);
   localparam logic [AW-1:0] RD_BASE  = AW'(NPIX);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_KICK   = 3'd2,
      ST_FILTER = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t        state_q;
   logic [CW-1:0] wr_cnt_q;
   logic [CW-1:0] rd_cnt_q;
   logic          rd_all_q;          // last read of the frame already issued
   logic          inflight_q;        // read issued last cycle, data on sram_dout now
   logic          inflight_last_q;   // that read was the final pixel
   logic [7:0]    fifo_data_q [2];
   logic [1:0]    fifo_last_q;
   logic          fifo_wr_ptr_q;
   logic          fifo_rd_ptr_q;
   logic [1:0]    fifo_cnt_q;

   logic          s_hs_s;
   logic          pop_s;
   logic          issue_s;
   logic [2:0]    occ_s;

   // Status and handshake decode, all taken from registered state.
   assign busy          = (state_q != ST_IDLE);
   assign s_ready       = (state_q == ST_LOAD);
   assign flt_start     = (state_q == ST_KICK);
   assign flt_owns_sram = (state_q == ST_KICK) || (state_q == ST_FILTER);
   assign frame_done    = (state_q == ST_DONE);
   assign m_valid       = (fifo_cnt_q != 2'd0);
   assign m_data        = fifo_data_q[fifo_rd_ptr_q];
   assign m_last        = fifo_last_q[fifo_rd_ptr_q];

   assign s_hs_s = s_valid & s_ready;
   assign pop_s  = m_valid & m_ready;

   // Buffered plus outstanding pixels, crediting this cycle's pop so a
   // continuously ready sink sees one beat per cycle.
   assign occ_s   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
   assign issue_s = (state_q == ST_DRAIN) && !rd_all_q && (occ_s < 3'd2);

   // SRAM port: load writes on accepted beats, drain reads when space allows.
   always_comb begin
      sram_cs   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = {AW{1'b0}};
      sram_din  = 8'h00;
      if (s_hs_s) begin
         sram_cs   = 1'b1;
         sram_we   = 1'b1;
         sram_addr = {1'b0, wr_cnt_q};
         sram_din  = s_data;
      end else if (issue_s) begin
         sram_cs   = 1'b1;
         sram_we   = 1'b0;
         sram_addr = RD_BASE + {1'b0, rd_cnt_q};
      end else begin
         sram_cs   = 1'b0;
      end
   end

   // Frame sequencing FSM with its load and read counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_cnt_q <= {CW{1'b0}};
         rd_cnt_q <= {CW{1'b0}};
         rd_all_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (frame_go) begin
                  state_q  <= ST_LOAD;
                  wr_cnt_q <= {CW{1'b0}};
               end
            end
            ST_LOAD: begin
               if (s_hs_s) begin
                  // Hold on the last index rather than wrapping within the frame.
                  if (wr_cnt_q == LAST_IDX) begin
                     state_q <= ST_KICK;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + 1'b1;
                  end
               end
            end
            ST_KICK: begin
               state_q  <= ST_FILTER;
               rd_cnt_q <= {CW{1'b0}};
               rd_all_q <= 1'b0;
            end
            ST_FILTER: begin
               if (flt_finish) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (issue_s) begin
                  if (rd_cnt_q == LAST_IDX) begin
                     rd_all_q <= 1'b1;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 1'b1;
                  end
               end
               if (pop_s && m_last) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Read-return capture into the 2-entry output FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= 8'h00;
         fifo_data_q[1]  <= 8'h00;
         fifo_last_q     <= 2'b00;
         fifo_wr_ptr_q   <= 1'b0;
         fifo_rd_ptr_q   <= 1'b0;
         fifo_cnt_q      <= 2'd0;
      end else begin
         inflight_q      <= issue_s;
         inflight_last_q <= issue_s && (rd_cnt_q == LAST_IDX);
         if (inflight_q) begin
            fifo_data_q[fifo_wr_ptr_q] <= sram_dout;
            fifo_last_q[fifo_wr_ptr_q] <= inflight_last_q;
            fifo_wr_ptr_q              <= ~fifo_wr_ptr_q;
         end
         if (pop_s) begin
            fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
         end
         fifo_cnt_q <= 2'(fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s});
      end
   end

endmodule
